// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES downstream reset domains in order (bit 0 first) after a
// minimum hold time, with a fixed gap between releases; sw_rst_req re-runs it.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  rst_done
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(STAGE_DELAY - 1);

  generate
    if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || STAGE_DELAY < 1) begin : g_param_check
      $error("reset_sequencer: NUM_STAGES, HOLD_CYCLES and STAGE_DELAY must all be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    done_q, done_d;
  logic [NUM_STAGES-1:0]   stage_shifted;

  // Shifting in zeros from the bottom keeps the outputs thermometer-coded.
  assign stage_shifted = stage_q << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      stage_q <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    done_d  = done_q;

    if (sw_rst_req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      stage_d = '1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_TC) begin
            cnt_d   = '0;
            stage_d = stage_shifted;
            if (stage_shifted == '0) begin
              done_d  = 1'b1;
              state_d = S_RUN;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == DELAY_TC) begin
            cnt_d   = '0;
            stage_d = stage_shifted;
            if (stage_shifted == '0) begin
              done_d  = 1'b1;
              state_d = S_RUN;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          stage_d = '1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign stage_rst_o = stage_q;
  assign rst_done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output changes are queued with
// the edge they must appear on; a negedge monitor pops and compares on each change.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       sw1 = 1'b0;
  logic [3:0] stage;
  logic       done;
  logic [0:0] stage1;
  logic       done1;

  reset_sequencer #(.NUM_STAGES(4), .HOLD_CYCLES(8), .STAGE_DELAY(16)) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .stage_rst_o(stage), .rst_done(done)
  );

  reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .sw_rst_req(sw1), .stage_rst_o(stage1), .rst_done(done1)
  );

  always #5 clk = ~clk;

  // Edge 1 is the first posedge sampled with rst low.
  int edge_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         at_edge;
    logic [3:0] stage;
    logic       done;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_at(input int e, input logic [3:0] s, input logic d);
    exp_t x;
    x.at_edge = e;
    x.stage   = s;
    x.done    = d;
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic goto_edge(input int n);
    int guard = 0;
    while (edge_cnt != n && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (edge_cnt != n) begin
      n_tests++;
      n_fail++;
      $display("FAIL goto_edge_timeout: got edge %0d, expected %0d", edge_cnt, n);
    end
  endtask

  function automatic bit thermo_ok(input logic [3:0] s);
    logic [3:0] z;
    z = ~s;
    return (z & (z + 4'd1)) == 4'd0;
  endfunction

  logic [4:0] prev_obs = 5'b11110;
  logic [4:0] cur_obs;
  exp_t       popped;

  always @(negedge clk) begin
    cur_obs = {stage, done};
    if (!$isunknown(cur_obs)) begin
      if (cur_obs !== prev_obs) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_change: got %b at edge %0d, expected no change from %b",
                   cur_obs, edge_cnt, prev_obs);
        end else begin
          popped = exp_q.pop_front();
          check($sformatf("edge_of_change_to_%b_%b", popped.stage, popped.done),
                edge_cnt, popped.at_edge);
          check($sformatf("value_at_edge_%0d", popped.at_edge),
                int'(cur_obs), int'({popped.stage, popped.done}));
        end
        prev_obs = cur_obs;
      end
      check("thermometer", int'(thermo_ok(stage)), 1);
      check("done_iff_zero", int'(done), int'(stage == 4'd0));
    end
    if (!$isunknown({stage1, done1}))
      check("single_done_iff_zero", int'(done1), int'(stage1 == 1'b0));
  end

  initial begin
    // Power-up and reset values
    #1 rst = 1'b1;
    #1;
    check("reset_stage", int'(stage), 'hF);
    check("reset_done", int'(done), 0);
    check("reset_stage1", int'(stage1), 1);
    check("reset_done1", int'(done1), 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    expect_at(8,  4'b1110, 1'b0);
    expect_at(24, 4'b1100, 1'b0);
    expect_at(40, 4'b1000, 1'b0);
    expect_at(56, 4'b0000, 1'b1);

    goto_edge(1);
    check("single_stage_edge1_stage", int'(stage1), 0);
    check("single_stage_edge1_done", int'(done1), 1);
    goto_edge(7);
    check("hold_edge7_stage", int'(stage), 'hF);

    goto_edge(69);
    sw1 = 1'b1;
    goto_edge(70);
    sw1 = 1'b0;
    check("single_sw_stage", int'(stage1), 1);
    check("single_sw_done", int'(done1), 0);
    goto_edge(71);
    check("single_rerelease_stage", int'(stage1), 0);
    check("single_rerelease_done", int'(done1), 1);

    // One-cycle software request in RUN
    goto_edge(99);
    sw_rst_req = 1'b1;
    expect_at(100, 4'b1111, 1'b0);
    expect_at(108, 4'b1110, 1'b0);
    expect_at(124, 4'b1100, 1'b0);
    expect_at(140, 4'b1000, 1'b0);
    expect_at(156, 4'b0000, 1'b1);
    goto_edge(100);
    sw_rst_req = 1'b0;

    // Request held for edges 200..209
    goto_edge(199);
    sw_rst_req = 1'b1;
    expect_at(200, 4'b1111, 1'b0);
    expect_at(217, 4'b1110, 1'b0);
    expect_at(233, 4'b1100, 1'b0);
    expect_at(249, 4'b1000, 1'b0);
    expect_at(265, 4'b0000, 1'b1);
    goto_edge(209);
    sw_rst_req = 1'b0;

    // Software request during RELEASE at edge 30
    goto_edge(280);
    expect_at(0, 4'b1111, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    expect_at(8,  4'b1110, 1'b0);
    expect_at(24, 4'b1100, 1'b0);
    goto_edge(29);
    sw_rst_req = 1'b1;
    expect_at(30, 4'b1111, 1'b0);
    expect_at(38, 4'b1110, 1'b0);
    expect_at(54, 4'b1100, 1'b0);
    expect_at(70, 4'b1000, 1'b0);
    expect_at(86, 4'b0000, 1'b1);
    goto_edge(30);
    sw_rst_req = 1'b0;

    // Async rst pulse between edges 45 and 46
    goto_edge(100);
    expect_at(0, 4'b1111, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_at(8,  4'b1110, 1'b0);
    expect_at(24, 4'b1100, 1'b0);
    expect_at(40, 4'b1000, 1'b0);
    goto_edge(45);
    expect_at(0, 4'b1111, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_stage", int'(stage), 'hF);
    check("async_rst_done", int'(done), 0);
    #1 rst = 1'b0;
    expect_at(8,  4'b1110, 1'b0);
    expect_at(24, 4'b1100, 1'b0);
    expect_at(40, 4'b1000, 1'b0);
    expect_at(56, 4'b0000, 1'b1);
    goto_edge(60);
    @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
